// File: rtl/count20b_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : count20b_pkg                                                  |
// | Purpose  : Shared definitions for the count20b period counter: the       |
// |            controller state encoding and the default counter width and   |
// |            minimum accepted period.                                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package count20b_pkg;

  localparam int unsigned DEF_WIDTH      = 20;
  localparam int unsigned DEF_MIN_PERIOD = 2;
  localparam int unsigned STATE_W        = 2;

  // IDLE must encode as all-zeros: the state flops clear to 0 on reset.
  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_e;

endpackage : count20b_pkg
`default_nettype wire

// File: rtl/D_FF.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : D_FF                                                          |
// | Purpose  : Single-bit D flip-flop cell with synchronous active-high      |
// |            clear.                                                        |
// | Ports    : clk  - clock (rising edge)                                    |
// |            rst  - synchronous active-high clear, q -> 0                  |
// |            d    - data in                                                |
// |            q    - registered data out                                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module D_FF (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule : D_FF
`default_nettype wire

// File: rtl/count20b.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : count20b                                                      |
// | Purpose  : Programmable down-counter. start latches a period P (clamped  |
// |            to at least MIN_PERIOD) and counts P..1; the edge after the   |
// |            count reads 1 emits a one-cycle tick. pause freezes the       |
// |            count, stop aborts. Command priority: stop > start > pause.   |
// | Config   : COUNT20B_AUTORELOAD_EN defined   -> reload P at expiry and    |
// |                                               keep running until stop  |
// |            COUNT20B_AUTORELOAD_EN undefined -> one-shot, return to IDLE  |
// | Ports    : Clock  - clock, all state changes on the rising edge         |
// |            Reset  - synchronous active-high reset, overrides commands    |
// |            start  - latch period and begin counting                      |
// |            stop   - abort counting                                       |
// |            pause  - freeze the count while high                          |
// |            period - cycles per count cycle (WIDTH bits)                  |
// |            num20b - current count value (registered)                     |
// |            tick   - one-cycle pulse at count expiry (registered)         |
// |            busy   - high whenever the state is not IDLE (registered)     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module count20b
  import count20b_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] num20b,
  output logic             tick,
  output logic             busy
);

  localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_MIN_PER = WIDTH'(MIN_PERIOD);

  state_e               state_q;
  state_e               state_d;
  logic [STATE_W-1:0]   state_bits_q;
  logic [STATE_W-1:0]   state_bits_d;

  logic [WIDTH-1:0]     num_q;
  logic [WIDTH-1:0]     num_d;
  logic                 tick_q;
  logic                 tick_d;
  logic                 busy_q;
  logic                 busy_d;
  logic [WIDTH-1:0]     load_val;

`ifdef COUNT20B_AUTORELOAD_EN
  // Latched period, needed only to reload the count at each expiry.
  logic [WIDTH-1:0]     p_q;
  logic [WIDTH-1:0]     p_d;
`endif

  // State register built from one D_FF cell per state bit.
  assign state_bits_d = state_d;
  assign state_q      = state_e'(state_bits_q);

  for (genvar i = 0; i < int'(STATE_W); i++) begin : g_state_bits
    D_FF u_state_ff (
      .clk (Clock),
      .rst (Reset),
      .d   (state_bits_d[i]),
      .q   (state_bits_q[i])
    );
  end

  // Requested period clamped up to the smallest supported value.
  assign load_val = (period < C_MIN_PER) ? C_MIN_PER : period;

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    tick_d  = 1'b0;
`ifdef COUNT20B_AUTORELOAD_EN
    p_d     = p_q;
`endif

    if (stop) begin
      state_d = IDLE;
      num_d   = '0;
    end else if (start) begin
      state_d = RUN;
      num_d   = load_val;
`ifdef COUNT20B_AUTORELOAD_EN
      p_d     = load_val;
`endif
    end else if (state_q != IDLE) begin
      if (pause) begin
        // Entering or staying in HOLD freezes the count on this edge.
        state_d = HOLD;
      end else begin
        // Leaving HOLD counts on the same edge, so a pause of N cycles
        // delays expiry by exactly N cycles.
        state_d = RUN;
        if (num_q == C_ONE) begin
          tick_d = 1'b1;
`ifdef COUNT20B_AUTORELOAD_EN
          num_d  = p_q;
`else
          num_d   = '0;
          state_d = IDLE;
`endif
        end else begin
          num_d = num_q - C_ONE;
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      num_q  <= '0;
      tick_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef COUNT20B_AUTORELOAD_EN
      p_q    <= '0;
`endif
    end else begin
      num_q  <= num_d;
      tick_q <= tick_d;
      busy_q <= busy_d;
`ifdef COUNT20B_AUTORELOAD_EN
      p_q    <= p_d;
`endif
    end
  end

  assign num20b = num_q;
  assign tick   = tick_q;
  assign busy   = busy_q;

endmodule : count20b
`default_nettype wire

// File: tb/tb_count20b.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_count20b                                                   |
// | Purpose  : Self-checking bench for count20b: directed scenarios with     |
// |            literal expectations plus randomized commands compared each   |
// |            cycle against an elapsed-cycle model of the counter.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_count20b;

  localparam int W = 20;
`ifdef COUNT20B_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         Clock;
  logic         Reset;
  logic         start;
  logic         stop;
  logic         pause;
  logic [W-1:0] period;
  logic [W-1:0] num20b;
  logic         tick;
  logic         busy;

  int checks = 0;
  int errors = 0;

  count20b #(.WIDTH(W), .MIN_PERIOD(2)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .start  (start),
    .stop   (stop),
    .pause  (pause),
    .period (period),
    .num20b (num20b),
    .tick   (tick),
    .busy   (busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Model: a run is described by its period P and the number of non-paused
  // cycles elapsed since the load. The count is P - (elapsed mod P); expiry
  // happens whenever elapsed reaches a multiple of P.
  bit          m_active  = 1'b0;
  int unsigned m_p       = 0;
  int unsigned m_el      = 0;
  bit          m_tick    = 1'b0;
  bit          m_started = 1'b0;

  always @(posedge Clock) begin
    m_started = 1'b1;
    m_tick    = 1'b0;
    if (Reset) begin
      m_active = 1'b0;
      m_p      = 0;
      m_el     = 0;
    end else if (stop) begin
      m_active = 1'b0;
    end else if (start) begin
      m_p      = (int'(period) < 2) ? 2 : int'(period);
      m_el     = 0;
      m_active = 1'b1;
    end else if (m_active && !pause) begin
      m_el++;
      if (m_el % m_p == 0) begin
        m_tick = 1'b1;
        if (!AUTO) m_active = 1'b0;
      end
    end
  end

  function automatic logic [W-1:0] exp_num();
    if (!m_active) return '0;
    return W'(m_p - (m_el % m_p));
  endfunction

  // Single compare process: every cycle after the first edge.
  always @(negedge Clock) begin
    if (m_started) begin
      checks++;
      if (num20b !== exp_num() || tick !== m_tick || busy !== m_active) begin
        errors++;
        $display("FAIL model t=%0t num20b=%0d tick=%0b busy=%0b required num20b=%0d tick=%0b busy=%0b",
                 $time, num20b, tick, busy, exp_num(), m_tick, m_active);
      end
    end
  end

  // Literal expectation check of all three outputs.
  task automatic chk(input string name, input int n, input bit t, input bit b);
    checks++;
    if (num20b !== W'(n) || tick !== t || busy !== b) begin
      errors++;
      $display("FAIL %s num20b=%0d tick=%0b busy=%0b required num20b=%0d tick=%0b busy=%0b",
               name, num20b, tick, busy, n, t, b);
    end
  endtask

  // Called at a falling edge: apply inputs, let one rising edge consume
  // them, return at the next falling edge with the new outputs settled.
  task automatic step(input bit r, input bit st, input bit sp, input bit pa,
                      input int per);
    Reset  = r;
    start  = st;
    stop   = sp;
    pause  = pa;
    period = W'(per);
    @(negedge Clock);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; period = '0;
    @(negedge Clock);

    // Reset state
    step(1, 1, 0, 0, 7);
    chk("reset", 0, 0, 0);
    step(0, 0, 0, 0, 9);
    chk("reset_idle", 0, 0, 0);

    // Basic count sequence
    if (AUTO) begin
      step(0, 1, 0, 0, 4); chk("ar_load4", 4, 0, 1);
      step(0, 0, 0, 0, 9); chk("ar_3", 3, 0, 1);
      step(0, 0, 0, 0, 0); chk("ar_2", 2, 0, 1);
      step(0, 0, 0, 0, 0); chk("ar_1", 1, 0, 1);
      step(0, 0, 0, 0, 0); chk("ar_reload4", 4, 1, 1);
      step(0, 0, 0, 0, 0); chk("ar_3b", 3, 0, 1);
      step(0, 0, 0, 0, 0); chk("ar_2b", 2, 0, 1);
      step(0, 0, 0, 0, 0); chk("ar_1b", 1, 0, 1);
      step(0, 0, 0, 0, 0); chk("ar_reload4b", 4, 1, 1);
      step(0, 0, 1, 0, 0); chk("ar_stop", 0, 0, 0);
    end else begin
      step(0, 1, 0, 0, 3); chk("os_load3", 3, 0, 1);
      step(0, 0, 0, 0, 8); chk("os_2", 2, 0, 1);
      step(0, 0, 0, 0, 0); chk("os_1", 1, 0, 1);
      step(0, 0, 0, 0, 0); chk("os_expire", 0, 1, 0);
      step(0, 0, 0, 0, 0); chk("os_hold0", 0, 0, 0);
      step(0, 0, 0, 1, 0); chk("os_hold0b", 0, 0, 0);
    end

    // Period below the minimum clamps to 2
    step(0, 1, 0, 0, 0); chk("p0_load", 2, 0, 1);
    step(0, 0, 0, 0, 0); chk("p0_1", 1, 0, 1);
    step(0, 0, 0, 0, 0); chk("p0_tick", AUTO ? 2 : 0, 1, AUTO);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1); chk("p1_load", 2, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0); chk("p1_tick", AUTO ? 2 : 0, 1, AUTO);
    step(0, 0, 1, 0, 0);

    // Pause for 3 cycles at count 3: expiry moves from 5 to 8 edges after start
    step(0, 1, 0, 0, 5); chk("pz_load", 5, 0, 1);
    step(0, 0, 0, 0, 0); chk("pz_4", 4, 0, 1);
    step(0, 0, 0, 0, 0); chk("pz_3", 3, 0, 1);
    step(0, 0, 0, 1, 2); chk("pz_hold1", 3, 0, 1);
    step(0, 0, 0, 1, 2); chk("pz_hold2", 3, 0, 1);
    step(0, 0, 0, 1, 2); chk("pz_hold3", 3, 0, 1);
    step(0, 0, 0, 0, 0); chk("pz_2", 2, 0, 1);
    step(0, 0, 0, 0, 0); chk("pz_1", 1, 0, 1);
    step(0, 0, 0, 0, 0); chk("pz_tick", AUTO ? 5 : 0, 1, AUTO);
    step(0, 0, 1, 0, 0);

    // stop beats start when the count reads 1
    step(0, 1, 0, 0, 2); chk("ss_load", 2, 0, 1);
    step(0, 0, 0, 0, 0); chk("ss_1", 1, 0, 1);
    step(0, 1, 1, 0, 6); chk("ss_stop", 0, 0, 0);
    step(0, 0, 0, 0, 0); chk("ss_after", 0, 0, 0);

    // Restart mid-count re-latches period without a tick
    step(0, 1, 0, 0, 3);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 6); chk("restart", 6, 0, 1);
    step(0, 0, 1, 0, 0);

    // Reset at count 2 wins and no tick follows
    step(0, 1, 0, 0, 4);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0); chk("rm_2", 2, 0, 1);
    step(1, 0, 0, 0, 0); chk("rm_reset", 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 9);
      chk("rm_quiet", 0, 0, 0);
    end

    // Randomized commands against the model
    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 150) == 0,
           ($urandom % 12) == 0,
           ($urandom % 60) == 0,
           ($urandom % 4) == 0,
           (($urandom % 8) == 0) ? int'($urandom_range(0, 40))
                                 : int'($urandom_range(0, 9)));
    end
    step(0, 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_count20b
`default_nettype wire
